sigmul_radix8_seq: RTL
======================

Name: sigmul_radix8_seq

Overview:
- Sequential radix-8 significand multiplier for the half-precision datapath.
- Each cycle it retires 3 multiplier bits: the 3-bit digit selects one of eight precomputed multiples (0·a..7·a) through a mux8to1 instance, and the selected multiple is accumulated with shift-add.
- Sits between operand unpack (upstream) and normalize/round (downstream).
- Uses a start/busy/done handshake with a registered product.

Parameters:
- NSIG, 10: stored fraction bits. Significand width W = NSIG+1 (hidden bit included).
- Derived, not overridable: ITER = ceil(W/3), which is 4 at the default. Multiple width MW = W+3. Product width PW = 2W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request. Sampled only in IDLE.
- a  in  W  multiplicand significand. Captured when start is accepted.
- b  in  W  multiplier significand. Captured when start is accepted.
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; product valid
- p  out  PW  unsigned product a·b. Registered; held until the next accepted start.
- norm  out  1  equals p[PW-1] (product ≥ 2.0, so a downstream right-shift is needed). Registered together with p.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; busy=0, done=0, p=0, norm=0.
  - Multiples, accumulator, multiplier shift register and iteration counter all cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is ever produced for it.
  - First start is accepted at the first edge after rst_n deasserts.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - On start=1 at edge E0: capture a into the multiplicand register.
  - Load b, zero-extended to 3·ITER bits, into the multiplier shift register.
  - Clear the accumulator and counter; go to LOAD.
  - start=0: stay in IDLE.
- LOAD (one cycle):
  - Register m0..m7 = k·a for k=0..7, each MW bits, exact with no truncation. 3a, 5a, 6a and 7a come from adders; 2a and 4a are shifts.
  - At E1 go to RUN.
- RUN (exactly ITER cycles, edges E2..E(ITER+1)):
  - sel = low 3 bits of the multiplier shift register. The mux output is m[sel].
  - sum = acc_hi + m[sel], computed at full width with no lost carry.
  - Accumulator shifts right 3; sum enters the top. The multiplier shift register shifts right 3.
  - The counter increments. When the counter reaches ITER-1, go to DONE and load p and norm from the accumulator's low PW bits.
- DONE (one cycle):
  - done=1, busy=1. Then return to IDLE.
  - p and norm stay stable from the entry to DONE until the edge that accepts the next start.
- Latency:
  - done is high in the cycle after edge E(ITER+1), i.e. 5 edges after the start sample at defaults.
  - Minimum start-to-start spacing is ITER+3 cycles.
- Handshake:
  - start while busy=1 (LOAD/RUN/DONE) is ignored; there is no queueing.
  - Operand changes while busy have no effect.
  - start may be held high continuously, which yields back-to-back operations.
- Arithmetic invariant: p == a·b exactly for all W-bit inputs, including 0. p never exceeds (2^W-1)², so no overflow is possible.
- Zero padding: the top multiplier digit uses zero fill (W=11 gives 12 bits, top bit 0). Digit values 0..7 only; no Booth recoding and no negative multiples.

Test Plan:
- Reset low, then release; check busy=0, done=0, p=0. Then a=0x400, b=0x400, pulse start → done exactly 5 edges after the start sample, p=0x100000, norm=0.
- a=0x7FF, b=0x7FF → p=0x3FF001, norm=1. a=0x600, b=0x600 → p=0x240000, norm=1.
- a=0x000, b=0x7FF → p=0, norm=0, done still pulses once. a=0x7FF, b=0x001 → p=0x0007FF.
- While busy (RUN), pulse start with a=0x555, b=0x2AA → ignored. The in-flight result is unchanged and exactly one done pulse occurs.
- Drop rst_n during RUN → all outputs 0 immediately (asynchronous), no done pulse. A subsequent start completes correctly.
- 10k random a, b with start held high → every p == a·b, done spacing exactly 7 cycles, p stable between done pulses.

Source files
------------

// File: rtl/sigmul_radix8_seq.sv
// ---------------------------------------------------------------------------
// sigmul_radix8_seq
//   Sequential radix-8 significand multiplier for the half-precision datapath.
//   It sits between operand unpack and normalize/round. Each RUN cycle
//   retires three multiplier bits: the digit picks one of eight precomputed
//   multiples (0*a .. 7*a), and that multiple is added into the accumulator,
//   which then shifts right by three.
//
// Ports
//   clk    in   1     rising-edge clock
//   rst_n  in   1     asynchronous active-low reset
//   start  in   1     request, sampled only in IDLE
//   a      in   W     multiplicand significand (hidden bit included)
//   b      in   W     multiplier significand (hidden bit included)
//   busy   out  1     high in every state except IDLE
//   done   out  1     one-cycle pulse, product valid
//   p      out  PW    unsigned product a*b, held until the next accepted start
//   norm   out  1     p[PW-1]: product >= 2.0, so downstream must right-shift
// ---------------------------------------------------------------------------

module mux8to1 #(
   parameter int W = 8
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  logic [W-1:0] d4,
   input  logic [W-1:0] d5,
   input  logic [W-1:0] d6,
   input  logic [W-1:0] d7,
   input  logic [2:0]   sel,
   output logic [W-1:0] y
);
   always_comb begin
      y = d0;
      case (sel)
         3'd0: y = d0;
         3'd1: y = d1;
         3'd2: y = d2;
         3'd3: y = d3;
         3'd4: y = d4;
         3'd5: y = d5;
         3'd6: y = d6;
         3'd7: y = d7;
         default: y = d0;
      endcase
   end
endmodule

module sigmul_radix8_seq #(
   parameter int NSIG = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NSIG:0]         a,
   input  logic [NSIG:0]         b,
   output logic                  busy,
   output logic                  done,
   output logic [2*NSIG+1:0]     p,
   output logic                  norm
);
   localparam int W    = NSIG + 1;
   localparam int ITER = (W + 2) / 3;
   localparam int MW   = W + 3;
   localparam int PW   = 2 * W;
   localparam int MBW  = 3 * ITER;
   // The accumulator holds MBW fraction bits below the MW-bit adder window, so
   // after ITER right-shifts of 3 its value is exactly a*b with no bits lost.
   localparam int AW   = MW + MBW;
   localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q;
   logic [MBW-1:0]  mb_q;
   logic [AW-1:0]   acc_q;
   logic [CW-1:0]   cnt_q;
   logic [MW-1:0]   m0_q, m1_q, m2_q, m3_q, m4_q, m5_q, m6_q, m7_q;
   logic [PW-1:0]   p_q;
   logic            norm_q;

   logic [MW-1:0]   a1, a2, a4;
   logic [MW-1:0]   mult_sel;
   logic [MW-1:0]   acc_hi;
   logic [MW:0]     sum;
   logic [AW:0]     acc_wide;
   logic [AW-1:0]   acc_nxt;
   logic            last;

   // Multiples are exact at MW = W+3 bits since 7*a < 8*2^W.
   assign a1 = MW'(a_q);
   assign a2 = a1 << 1;
   assign a4 = a1 << 2;

   mux8to1 #(.W(MW)) u_mux (
      .d0  (m0_q),
      .d1  (m1_q),
      .d2  (m2_q),
      .d3  (m3_q),
      .d4  (m4_q),
      .d5  (m5_q),
      .d6  (m6_q),
      .d7  (m7_q),
      .sel (mb_q[2:0]),
      .y   (mult_sel)
   );

   // One extra bit on the add keeps the carry; the right shift by 3 then
   // drops the three lowest accumulator bits, which are finished product bits
   // only once they have been shifted below bit 0... they never are, because
   // the fraction field is exactly 3*ITER bits wide.
   assign acc_hi   = acc_q[AW-1 -: MW];
   assign sum      = {1'b0, acc_hi} + {1'b0, mult_sel};
   assign acc_wide = {sum, acc_q[AW-MW-1:0]};
   assign acc_nxt  = {2'b00, acc_wide[AW:3]};
   assign last     = (cnt_q == CW'(ITER - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = LOAD;
         end
         LOAD: state_d = RUN;
         RUN:  if (last) state_d = DONE;
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         mb_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         m0_q   <= '0;
         m1_q   <= '0;
         m2_q   <= '0;
         m3_q   <= '0;
         m4_q   <= '0;
         m5_q   <= '0;
         m6_q   <= '0;
         m7_q   <= '0;
         p_q    <= '0;
         norm_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  // Zero fill of the top digit: no Booth recoding.
                  mb_q  <= MBW'(b);
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            LOAD: begin
               m0_q <= '0;
               m1_q <= a1;
               m2_q <= a2;
               m3_q <= a1 + a2;
               m4_q <= a4;
               m5_q <= a1 + a4;
               m6_q <= a2 + a4;
               m7_q <= a1 + a2 + a4;
            end
            RUN: begin
               acc_q <= acc_nxt;
               mb_q  <= mb_q >> 3;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  p_q    <= acc_nxt[PW-1:0];
                  norm_q <= acc_nxt[PW-1];
               end
            end
            default: ;
         endcase
      end
   end

   assign p    = p_q;
   assign norm = norm_q;
endmodule
